// File: rtl/data_cache_pkg.sv
// Shared types and width constants for the direct-mapped write-back data cache.
// Imported by the cache top level and its per-set storage array.
package cache_types;

    localparam int ADDR_W       = 32;
    localparam int WORD_W       = 32;
    localparam int BE_W         = 4;
    localparam int DEF_S_INDEX  = 3;
    localparam int DEF_S_OFFSET = 5;
    localparam int DEF_TAG_W    = ADDR_W - DEF_S_INDEX - DEF_S_OFFSET;
    localparam int DEF_LINE_W   = 8 << DEF_S_OFFSET;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WRITEBACK = 2'b01,
        ST_ALLOCATE  = 2'b10
    } cache_state_e;

    // Byte-lane merge used for CPU store hits into a stored word.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Per-set storage: valid/dirty flags (reset), tag and line data (no reset).
// Supports a full-line fill or a byte-enabled single-word store per cycle.
module cache_array
    import cache_types::*;
#(
    parameter int S_INDEX  = DEF_S_INDEX,
    parameter int S_OFFSET = DEF_S_OFFSET
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [S_INDEX-1:0]                    index,
    input  logic [S_OFFSET-3:0]                   word_sel,
    input  logic                                  line_load,
    input  logic [(8<<S_OFFSET)-1:0]              line_in,
    input  logic                                  word_we,
    input  logic [BE_W-1:0]                       word_be,
    input  logic [WORD_W-1:0]                     word_in,
    input  logic                                  valid_load,
    input  logic                                  valid_in,
    input  logic                                  dirty_load,
    input  logic                                  dirty_in,
    input  logic                                  tag_load,
    input  logic [ADDR_W-S_INDEX-S_OFFSET-1:0]    tag_in,
    output logic                                  valid_out,
    output logic                                  dirty_out,
    output logic [ADDR_W-S_INDEX-S_OFFSET-1:0]    tag_out,
    output logic [(8<<S_OFFSET)-1:0]              line_out
);

    localparam int SETS   = 1 << S_INDEX;
    localparam int LINE_W = 8 << S_OFFSET;
    localparam int TAG_W  = ADDR_W - S_INDEX - S_OFFSET;

    logic [SETS-1:0]   valid_r;
    logic [SETS-1:0]   dirty_r;
    logic [TAG_W-1:0]  tag_mem_r  [SETS];
    logic [LINE_W-1:0] data_mem_r [SETS];

    // Valid and dirty flags; cleared by reset so every line starts invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else begin
            if (valid_load) begin
                valid_r[index] <= valid_in;
            end
            if (dirty_load) begin
                dirty_r[index] <= dirty_in;
            end
        end
    end

    // Tag storage
    always_ff @(posedge clk) begin
        if (tag_load) begin
            tag_mem_r[index] <= tag_in;
        end
    end

    // Line data: a fill takes priority over a word store
    always_ff @(posedge clk) begin
        if (line_load) begin
            data_mem_r[index] <= line_in;
        end else if (word_we) begin
            data_mem_r[index][word_sel*WORD_W +: WORD_W] <=
                merge_bytes(data_mem_r[index][word_sel*WORD_W +: WORD_W], word_in, word_be);
        end
    end

    assign valid_out = valid_r[index];
    assign dirty_out = dirty_r[index];
    assign tag_out   = tag_mem_r[index];
    assign line_out  = data_mem_r[index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a single-line
// memory port. Hits complete in the request cycle; misses evict then fill.
module data_cache
    import cache_types::*;
#(
    parameter int S_INDEX  = DEF_S_INDEX,
    parameter int S_OFFSET = DEF_S_OFFSET
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        mem_address,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [BE_W-1:0]          mem_byte_enable,
    input  logic [WORD_W-1:0]        mem_wdata,
    output logic [WORD_W-1:0]        mem_rdata,
    output logic                     mem_resp,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [(8<<S_OFFSET)-1:0] pmem_wdata,
    input  logic [(8<<S_OFFSET)-1:0] pmem_rdata,
    input  logic                     pmem_resp
);

    localparam int TAG_W  = ADDR_W - S_INDEX - S_OFFSET;
    localparam int LINE_W = 8 << S_OFFSET;
    localparam int WSEL_W = S_OFFSET - 2;

    cache_state_e      state_r;
    cache_state_e      next_state_s;

    logic [TAG_W-1:0]  addr_tag_s;
    logic [S_INDEX-1:0] index_s;
    logic [WSEL_W-1:0] word_s;
    logic              unused_addr_bits_s;

    logic              req_s;
    logic              hit_s;
    logic              valid_s;
    logic              dirty_s;
    logic [TAG_W-1:0]  tag_s;
    logic [LINE_W-1:0] line_s;

    logic              line_load_s;
    logic              word_we_s;
    logic              valid_load_s;
    logic              valid_in_s;
    logic              dirty_load_s;
    logic              dirty_in_s;
    logic              tag_load_s;

    assign addr_tag_s         = mem_address[ADDR_W-1 -: TAG_W];
    assign index_s            = mem_address[S_OFFSET +: S_INDEX];
    assign word_s             = mem_address[2 +: WSEL_W];
    assign unused_addr_bits_s = ^mem_address[1:0];

    // A simultaneous read and write is serviced as a write, so any strobe is a request
    assign req_s = mem_read | mem_write;
    assign hit_s = valid_s & (tag_s == addr_tag_s);

    cache_array #(
        .S_INDEX  (S_INDEX),
        .S_OFFSET (S_OFFSET)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .index      (index_s),
        .word_sel   (word_s),
        .line_load  (line_load_s),
        .line_in    (pmem_rdata),
        .word_we    (word_we_s),
        .word_be    (mem_byte_enable),
        .word_in    (mem_wdata),
        .valid_load (valid_load_s),
        .valid_in   (valid_in_s),
        .dirty_load (dirty_load_s),
        .dirty_in   (dirty_in_s),
        .tag_load   (tag_load_s),
        .tag_in     (addr_tag_s),
        .valid_out  (valid_s),
        .dirty_out  (dirty_s),
        .tag_out    (tag_s),
        .line_out   (line_s)
    );

    // Controller state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, handshake strobes and array write controls
    always_comb begin
        next_state_s = state_r;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        line_load_s  = 1'b0;
        word_we_s    = 1'b0;
        valid_load_s = 1'b0;
        valid_in_s   = 1'b0;
        dirty_load_s = 1'b0;
        dirty_in_s   = 1'b0;
        tag_load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && hit_s) begin
                    mem_resp = 1'b1;
                    if (mem_write) begin
                        word_we_s    = 1'b1;
                        dirty_load_s = 1'b1;
                        dirty_in_s   = 1'b1;
                    end else begin
                        word_we_s    = 1'b0;
                    end
                end else if (req_s) begin
                    if (valid_s && dirty_s) begin
                        next_state_s = ST_WRITEBACK;
                    end else begin
                        next_state_s = ST_ALLOCATE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_s, index_s, {S_OFFSET{1'b0}}};
                pmem_wdata   = line_s;
                if (pmem_resp) begin
                    next_state_s = ST_ALLOCATE;
                end else begin
                    next_state_s = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {addr_tag_s, index_s, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    line_load_s  = 1'b1;
                    valid_load_s = 1'b1;
                    valid_in_s   = 1'b1;
                    dirty_load_s = 1'b1;
                    dirty_in_s   = 1'b0;
                    tag_load_s   = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ALLOCATE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Read data is the selected word while idle; an invalid line returns zero
    // so the unreset data array never leaks onto the bus after reset.
    always_comb begin
        mem_rdata = '0;
        if ((state_r == ST_IDLE) && valid_s) begin
            mem_rdata = line_s[word_s*WORD_W +: WORD_W];
        end else begin
            mem_rdata = '0;
        end
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, meaning log2 of the number of sets (8 lines).
REQ-002 SHALL have parameter S_OFFSET, default 5, meaning log2 of the line size in bytes (32-byte, 256-bit lines).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mem_address, input, 32 bits: CPU word address; bits [1:0] are ignored.
REQ-006 SHALL have port mem_read, input, 1 bit: CPU read request.
REQ-007 SHALL have port mem_write, input, 1 bit: CPU write request.
REQ-008 SHALL have port mem_byte_enable, input, 4 bits: write byte lanes.
REQ-009 SHALL have port mem_wdata, input, 32 bits: CPU write data.
REQ-010 SHALL have port mem_rdata, output, 32 bits: CPU read data.
REQ-011 SHALL have port mem_resp, output, 1 bit: request complete.
REQ-012 SHALL have port pmem_address, output, 32 bits: line-aligned memory address, low S_OFFSET bits zero.
REQ-013 SHALL have ports pmem_read and pmem_write, output, 1 bit each: memory line request strobes.
REQ-014 SHALL have port pmem_wdata, output, 256 bits: victim line data.
REQ-015 SHALL have port pmem_rdata, input, 256 bits: fill line data.
REQ-016 SHALL have port pmem_resp, input, 1 bit: memory transfer complete.

Function
REQ-017 SHALL be a direct-mapped, write-back, write-allocate cache; address split: tag [31:8], index [7:5], word [4:2].
REQ-018 SHALL keep, per set: valid bit, dirty bit, 24-bit tag, 256-bit data.
REQ-019 SHALL implement the state machine IDLE -> WRITEBACK -> ALLOCATE -> IDLE, with IDLE -> ALLOCATE directly on a clean miss.
REQ-020 SHALL, in IDLE on a hit (valid and tag equal), assert mem_resp combinationally in the same cycle; a hit has 0 extra cycles of latency.
REQ-021 SHALL drive mem_rdata with line word [4:2] whenever in IDLE; the value is valid when mem_resp=1 on a read.
REQ-022 SHALL, on a write hit, update only the bytes with mem_byte_enable set in word [4:2] at the clock edge, and set dirty.
REQ-023 SHALL treat mem_read and mem_write both high as a write.
REQ-024 SHALL, on a miss with valid and dirty set, go to WRITEBACK; otherwise go to ALLOCATE; mem_resp stays 0.
REQ-025 SHALL, in WRITEBACK, hold pmem_write=1, pmem_address={stored tag, index, 5'b0}, and pmem_wdata=line until pmem_resp, then go to ALLOCATE.
REQ-026 SHALL, in ALLOCATE, hold pmem_read=1 and pmem_address={tag, index, 5'b0} until pmem_resp; then load pmem_rdata, set valid, clear dirty, write the tag, and return to IDLE.
REQ-027 SHALL, after a fill, service the still-held request as a hit in IDLE one cycle later.
REQ-028 SHALL require the CPU to hold address, strobes, byte enable, and wdata stable until mem_resp; changing them earlier is illegal.
REQ-029 SHALL never assert pmem_read and pmem_write together, and SHALL deassert both in IDLE.
REQ-030 SHALL ignore pmem_resp outside WRITEBACK and ALLOCATE.
REQ-031 SHALL do nothing, with mem_resp=0, in IDLE when no request is present.

Reset
REQ-032 SHALL, on rst=0 at any time, including mid-WRITEBACK or mid-ALLOCATE, immediately enter IDLE, clear all valid and dirty bits, and drive pmem_read=0, pmem_write=0, and mem_resp=0.
REQ-033 SHALL reset pmem_address, pmem_wdata, and mem_rdata to 0; tag and data arrays need no reset.

Structure
REQ-034 SHALL place the state enum and the tag, index, and offset width constants in the shared package cache_types.
REQ-035 SHALL instantiate one sub-module, cache_array: per-set storage with a 32-bit byte-enabled line write and separate valid, dirty, and tag load controls.

Verification
REQ-036 Cold read 0x0000_0104 -> pmem_read with pmem_address 0x0000_0100; after pmem_resp with line word1=0xDEAD_BEEF -> mem_resp next cycle, mem_rdata 0xDEAD_BEEF.
REQ-037 Write hit 0x104, byte_enable 4'b0011, wdata 0x1234_5678 -> same-cycle mem_resp; a later read returns 0xDEAD_5678 and dirty=1.
REQ-038 Read 0x0001_0104 (same index, new tag) after REQ-037 -> pmem_write at 0x100 carrying 0xDEAD_5678 in word1, then pmem_read at 0x0001_0100, then mem_resp.
REQ-039 Assert rst=0 during ALLOCATE with pmem_resp pending -> strobes drop immediately; a reread of 0x104 misses.
REQ-040 mem_read and mem_write both high on a hit -> treated as a write, data updated, dirty set.
